id_operand_stage: RTL and testbench

Decode/operand-fetch stage of the pipelined core: the read-side client of the register file. It drives the regfile read addresses from the IF/ID instruction and bypasses the same-cycle writeback value. It detects load-use hazards and registers operands into the ID/EX pipeline register with a valid/ready handshake. Its write-port inputs are the same signals that drive the regfile's write port.

---
 rtl/id_operand_if.sv | 55 +++++
 rtl/id_operand_stage.sv | 147 ++++++++++++++
 tb/tb_id_operand_stage.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_operand_if.sv
// Bus between the IF/ID register, the regfile ports and the ID/EX register
// as seen by the decode/operand-fetch stage. The stage is the slave side;
// the surrounding pipeline (or a testbench) is the master side.
interface id_operand_if #(
    parameter int XLEN = 32
);
    logic            if_valid;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic            id_ready;

    logic [4:0]      rf_ra1;
    logic [4:0]      rf_ra2;
    logic [XLEN-1:0] rf_rd1;
    logic [XLEN-1:0] rf_rd2;

    logic            wb_we;
    logic [4:0]      wb_wa;
    logic [XLEN-1:0] wb_wd;

    logic            ex_ready;
    logic            ex_flush;
    logic            ex_valid;
    logic [31:0]     ex_instr;
    logic [XLEN-1:0] ex_pc;
    logic [4:0]      ex_rs1;
    logic [4:0]      ex_rs2;
    logic [4:0]      ex_rd;
    logic [XLEN-1:0] ex_rs1_val;
    logic [XLEN-1:0] ex_rs2_val;
    logic            ex_rd_we;
    logic            ex_is_load;

    modport slave (
        input  if_valid, if_instr, if_pc,
        output id_ready,
        output rf_ra1, rf_ra2,
        input  rf_rd1, rf_rd2,
        input  wb_we, wb_wa, wb_wd,
        input  ex_ready, ex_flush,
        output ex_valid, ex_instr, ex_pc, ex_rs1, ex_rs2, ex_rd,
        output ex_rs1_val, ex_rs2_val, ex_rd_we, ex_is_load
    );

    modport master (
        output if_valid, if_instr, if_pc,
        input  id_ready,
        input  rf_ra1, rf_ra2,
        output rf_rd1, rf_rd2,
        output wb_we, wb_wa, wb_wd,
        output ex_ready, ex_flush,
        input  ex_valid, ex_instr, ex_pc, ex_rs1, ex_rs2, ex_rd,
        input  ex_rs1_val, ex_rs2_val, ex_rd_we, ex_is_load
    );
endinterface

// File: rtl/id_operand_stage.sv
// Decode / operand-fetch stage. Reads the regfile for the IF/ID instruction,
// bypasses a same-cycle writeback, stalls one cycle on a load-use hazard and
// registers the decoded instruction plus operands into the ID/EX register.
module id_operand_stage #(
    parameter int XLEN = 32
) (
    input logic          clk,
    input logic          rst_n,
    id_operand_if.slave  bus
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    logic [6:0]      opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rs1_used;
    logic            rs2_used;
    logic            rd_written;
    logic            is_load;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            hazard;

    logic            ex_valid_q;
    logic [31:0]     ex_instr_q;
    logic [XLEN-1:0] ex_pc_q;
    logic [4:0]      ex_rs1_q;
    logic [4:0]      ex_rs2_q;
    logic [4:0]      ex_rd_q;
    logic [XLEN-1:0] ex_rs1_val_q;
    logic [XLEN-1:0] ex_rs2_val_q;
    logic            ex_rd_we_q;
    logic            ex_is_load_q;

    assign opcode = bus.if_instr[6:0];
    assign rd     = bus.if_instr[11:7];
    assign rs1    = bus.if_instr[19:15];
    assign rs2    = bus.if_instr[24:20];

    assign bus.rf_ra1 = rs1;
    assign bus.rf_ra2 = rs2;

    // Classify which register fields the opcode actually reads and writes
    always_comb begin
        rs1_used   = 1'b0;
        rs2_used   = 1'b0;
        rd_written = 1'b0;
        is_load    = 1'b0;
        case (opcode)
            OPC_OP:     begin rs1_used = 1'b1; rs2_used = 1'b1; rd_written = 1'b1; end
            OPC_OPIMM:  begin rs1_used = 1'b1; rd_written = 1'b1; end
            OPC_LOAD:   begin rs1_used = 1'b1; rd_written = 1'b1; is_load = 1'b1; end
            OPC_STORE:  begin rs1_used = 1'b1; rs2_used = 1'b1; end
            OPC_BRANCH: begin rs1_used = 1'b1; rs2_used = 1'b1; end
            OPC_JALR:   begin rs1_used = 1'b1; rd_written = 1'b1; end
            OPC_LUI:    rd_written = 1'b1;
            OPC_AUIPC:  rd_written = 1'b1;
            OPC_JAL:    rd_written = 1'b1;
            default:    ;
        endcase
    end

    // Operand select: x0 is hard zero, then the writeback bypass, then the regfile
    always_comb begin
        rs1_val = bus.rf_rd1;
        rs2_val = bus.rf_rd2;
        if (rs1 == 5'd0) begin
            rs1_val = '0;
        end else if (bus.wb_we && (bus.wb_wa == rs1)) begin
            rs1_val = bus.wb_wd;
        end
        if (rs2 == 5'd0) begin
            rs2_val = '0;
        end else if (bus.wb_we && (bus.wb_wa == rs2)) begin
            rs2_val = bus.wb_wd;
        end
    end

    // A load in ID/EX whose destination feeds a used source must wait one cycle;
    // ex_rd_we already excludes x0 as a destination
    always_comb begin
        hazard = bus.if_valid && ex_valid_q && ex_is_load_q && ex_rd_we_q &&
                 ((rs1_used && (ex_rd_q == rs1)) || (rs2_used && (ex_rd_q == rs2)));
    end

    assign bus.id_ready = bus.ex_ready && !hazard;

    // ID/EX register: flush beats hold, hold beats bubble, bubble beats capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_instr_q   <= '0;
            ex_pc_q      <= '0;
            ex_rs1_q     <= '0;
            ex_rs2_q     <= '0;
            ex_rd_q      <= '0;
            ex_rs1_val_q <= '0;
            ex_rs2_val_q <= '0;
            ex_rd_we_q   <= 1'b0;
            ex_is_load_q <= 1'b0;
        end else if (bus.ex_flush) begin
            ex_valid_q <= 1'b0;
        end else if (!bus.ex_ready) begin
            if (ex_valid_q && bus.wb_we && (bus.wb_wa == ex_rs1_q) && (ex_rs1_q != 5'd0)) begin
                ex_rs1_val_q <= bus.wb_wd;
            end
            if (ex_valid_q && bus.wb_we && (bus.wb_wa == ex_rs2_q) && (ex_rs2_q != 5'd0)) begin
                ex_rs2_val_q <= bus.wb_wd;
            end
        end else if (hazard) begin
            ex_valid_q <= 1'b0;
        end else begin
            ex_valid_q   <= bus.if_valid;
            ex_instr_q   <= bus.if_instr;
            ex_pc_q      <= bus.if_pc;
            ex_rs1_q     <= rs1;
            ex_rs2_q     <= rs2;
            ex_rd_q      <= rd;
            ex_rs1_val_q <= rs1_val;
            ex_rs2_val_q <= rs2_val;
            ex_rd_we_q   <= rd_written && (rd != 5'd0);
            ex_is_load_q <= is_load;
        end
    end

    assign bus.ex_valid   = ex_valid_q;
    assign bus.ex_instr   = ex_instr_q;
    assign bus.ex_pc      = ex_pc_q;
    assign bus.ex_rs1     = ex_rs1_q;
    assign bus.ex_rs2     = ex_rs2_q;
    assign bus.ex_rd      = ex_rd_q;
    assign bus.ex_rs1_val = ex_rs1_val_q;
    assign bus.ex_rs2_val = ex_rs2_val_q;
    assign bus.ex_rd_we   = ex_rd_we_q;
    assign bus.ex_is_load = ex_is_load_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Testbench for id_operand_stage: a table of single-instruction vectors run
// through a scoreboard queue, then hand-written multi-cycle sequences for
// load-use stalls, backpressure refresh, flush priority and async reset.
module tb_id_operand_stage;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;

    typedef struct {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        wb_we;
        logic [4:0]  wb_wa;
        logic [31:0] wb_wd;
        logic        exp_valid;
        logic [4:0]  exp_rs1;
        logic [4:0]  exp_rs2;
        logic [4:0]  exp_rd;
        logic [31:0] exp_v1;
        logic [31:0] exp_v2;
        logic        exp_rd_we;
        logic        exp_load;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   passes;
    vec_t vecs[12];
    vec_t sb[$];

    id_operand_if #(.XLEN(32)) bus ();

    id_operand_stage #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3,
                                        input logic [4:0] rdi, input logic [6:0] opc);
        return {f7, r2, r1, f3, rdi, opc};
    endfunction

    function automatic vec_t mkVec(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] d1, input logic [31:0] d2,
                                   input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                   input logic ev, input logic [4:0] e1, input logic [4:0] e2,
                                   input logic [4:0] erd, input logic [31:0] ev1,
                                   input logic [31:0] ev2, input logic ewe, input logic eld);
        vec_t r;
        r.valid = v; r.instr = ins; r.pc = pc; r.rd1 = d1; r.rd2 = d2;
        r.wb_we = we; r.wb_wa = wa; r.wb_wd = wd;
        r.exp_valid = ev; r.exp_rs1 = e1; r.exp_rs2 = e2; r.exp_rd = erd;
        r.exp_v1 = ev1; r.exp_v2 = ev2; r.exp_rd_we = ewe; r.exp_load = eld;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic driveIf(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                           input logic [31:0] d1, input logic [31:0] d2,
                           input logic we, input logic [4:0] wa, input logic [31:0] wd);
        bus.if_valid = v;
        bus.if_instr = ins;
        bus.if_pc    = pc;
        bus.rf_rd1   = d1;
        bus.rf_rd2   = d2;
        bus.wb_we    = we;
        bus.wb_wa    = wa;
        bus.wb_wd    = wd;
    endtask

    // Drive one vector, check the combinational outputs, queue its expectation
    task automatic applyStimulus(input vec_t v);
        driveIf(v.valid, v.instr, v.pc, v.rd1, v.rd2, v.wb_we, v.wb_wa, v.wb_wd);
        bus.ex_ready = 1'b1;
        bus.ex_flush = 1'b0;
        #1;
        checkOutput("rf_ra1", 32'(bus.rf_ra1), 32'(v.exp_rs1));
        checkOutput("rf_ra2", 32'(bus.rf_ra2), 32'(v.exp_rs2));
        checkOutput("id_ready", 32'(bus.id_ready), 32'd1);
        sb.push_back(v);
    endtask

    // Pop the oldest expectation and compare it with the ID/EX register
    task automatic popAndCompare();
        vec_t e;
        if (sb.size() == 0) begin
            checkOutput("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        checkOutput("ex_valid", 32'(bus.ex_valid), 32'(e.exp_valid));
        if (e.exp_valid) begin
            checkOutput("ex_instr", bus.ex_instr, e.instr);
            checkOutput("ex_pc", bus.ex_pc, e.pc);
            checkOutput("ex_rs1", 32'(bus.ex_rs1), 32'(e.exp_rs1));
            checkOutput("ex_rs2", 32'(bus.ex_rs2), 32'(e.exp_rs2));
            checkOutput("ex_rd", 32'(bus.ex_rd), 32'(e.exp_rd));
            checkOutput("ex_rs1_val", bus.ex_rs1_val, e.exp_v1);
            checkOutput("ex_rs2_val", bus.ex_rs2_val, e.exp_v2);
            checkOutput("ex_rd_we", 32'(bus.ex_rd_we), 32'(e.exp_rd_we));
            checkOutput("ex_is_load", 32'(bus.ex_is_load), 32'(e.exp_load));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Place LW x5,0(x1) into ID/EX
    task automatic loadInEx();
        bus.ex_ready = 1'b1;
        bus.ex_flush = 1'b0;
        driveIf(1'b1, enc(7'd0, 5'd0, 5'd1, 3'd2, 5'd5, LOAD), 32'h200, 32'h40, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        checkOutput("lw_in_ex_load", 32'(bus.ex_is_load), 32'd1);
    endtask

    initial begin
        logic [31:0] add_x6_x5_x4;
        logic [31:0] sub_x7_x5_x4;
        checks = 0;
        passes = 0;

        vecs[0]  = mkVec(1, enc(0, 2, 1, 0, 3, OP), 32'h100, 5, 7, 0, 0, 0,
                         1, 1, 2, 3, 5, 7, 1, 0);
        vecs[1]  = mkVec(1, enc(0, 2, 1, 0, 3, OP), 32'h104, 5, 7, 1, 1, 32'hAA,
                         1, 1, 2, 3, 32'hAA, 7, 1, 0);
        vecs[2]  = mkVec(1, enc(0, 2, 0, 0, 3, OP), 32'h108, 32'h55, 7, 1, 0, 32'hBB,
                         1, 0, 2, 3, 0, 7, 1, 0);
        vecs[3]  = mkVec(1, enc(0, 5, 1, 0, 0, OPIMM), 32'h10C, 32'h11, 32'h9, 0, 0, 0,
                         1, 1, 5, 0, 32'h11, 32'h9, 0, 0);
        vecs[4]  = mkVec(1, enc(1, 3, 8, 2, 6, LUI), 32'h110, 32'h21, 32'h22, 0, 0, 0,
                         1, 8, 3, 6, 32'h21, 32'h22, 1, 0);
        vecs[5]  = mkVec(1, enc(0, 0, 1, 2, 5, LOAD), 32'h114, 32'h40, 32'h99, 0, 0, 0,
                         1, 1, 0, 5, 32'h40, 0, 1, 1);
        vecs[6]  = mkVec(1, enc(0, 5, 5, 0, 1, JAL), 32'h118, 32'h31, 32'h32, 0, 0, 0,
                         1, 5, 5, 1, 32'h31, 32'h32, 1, 0);
        vecs[7]  = mkVec(1, enc(0, 3, 2, 0, 4, BRANCH), 32'h11C, 32'h41, 32'h42, 1, 3, 32'h333,
                         1, 2, 3, 4, 32'h41, 32'h333, 0, 0);
        vecs[8]  = mkVec(1, enc(3, 6, 7, 1, 9, AUIPC), 32'h120, 32'h51, 32'h52, 0, 7, 32'hDEAD,
                         1, 7, 6, 9, 32'h51, 32'h52, 1, 0);
        vecs[9]  = mkVec(0, enc(0, 3, 2, 2, 0, STORE), 32'h124, 32'h61, 32'h62, 0, 0, 0,
                         0, 2, 3, 0, 32'h61, 32'h62, 0, 0);
        vecs[10] = mkVec(1, enc(0, 0, 5, 0, 1, JALR), 32'h128, 32'h71, 32'h72, 1, 5, 32'h77,
                         1, 5, 0, 1, 32'h77, 0, 1, 0);
        vecs[11] = mkVec(1, enc(0, 3, 2, 2, 0, STORE), 32'h12C, 32'h61, 32'h62, 1, 0, 32'hEE,
                         1, 2, 3, 0, 32'h61, 32'h62, 0, 0);

        add_x6_x5_x4 = enc(7'd0, 5'd4, 5'd5, 3'd0, 5'd6, OP);
        sub_x7_x5_x4 = enc(7'h20, 5'd4, 5'd5, 3'd0, 5'd7, OP);

        // Reset with random inputs
        rst_n = 1'b0;
        bus.ex_ready = 1'($urandom);
        bus.ex_flush = 1'($urandom);
        driveIf(1'($urandom), $urandom, $urandom, $urandom, $urandom, 1'($urandom), 5'($urandom), $urandom);
        repeat (3) tick();
        checkOutput("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        checkOutput("rst_ex_instr", bus.ex_instr, 32'd0);
        checkOutput("rst_ex_pc", bus.ex_pc, 32'd0);
        checkOutput("rst_ex_regs", {17'd0, bus.ex_rs1, bus.ex_rs2, bus.ex_rd}, 32'd0);
        checkOutput("rst_ex_vals", bus.ex_rs1_val | bus.ex_rs2_val, 32'd0);
        checkOutput("rst_ex_flags", {30'd0, bus.ex_rd_we, bus.ex_is_load}, 32'd0);
        #2 rst_n = 1'b1;
        tick();

        // Table vectors through the scoreboard
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            tick();
            popAndCompare();
        end
        driveIf(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();

        // Load-use: one bubble, then the dependent ADD is captured
        loadInEx();
        driveIf(1'b1, add_x6_x5_x4, 32'h204, 32'h70, 32'h80, 1'b0, 5'd0, 32'h0);
        #1 checkOutput("lu_stall_ready", 32'(bus.id_ready), 32'd0);
        tick();
        checkOutput("lu_bubble", 32'(bus.ex_valid), 32'd0);
        checkOutput("lu_resume_ready", 32'(bus.id_ready), 32'd1);
        tick();
        checkOutput("lu_add_valid", 32'(bus.ex_valid), 32'd1);
        checkOutput("lu_add_instr", bus.ex_instr, add_x6_x5_x4);
        checkOutput("lu_add_rs1_val", bus.ex_rs1_val, 32'h70);

        // LUI reads nothing, so no stall even with x5 in its rs1 field
        loadInEx();
        driveIf(1'b1, enc(7'd0, 5'd0, 5'd5, 3'd0, 5'd6, LUI), 32'h208, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1 checkOutput("lui_no_stall", 32'(bus.id_ready), 32'd1);
        tick();
        checkOutput("lui_valid", 32'(bus.ex_valid), 32'd1);
        checkOutput("lui_rd", 32'(bus.ex_rd), 32'd6);

        // Backpressure: held SUB picks up the writeback of x4
        driveIf(1'b1, sub_x7_x5_x4, 32'h300, 32'h50, 32'h10, 1'b0, 5'd0, 32'h0);
        tick();
        checkOutput("bp_initial_rs2", bus.ex_rs2_val, 32'h10);
        bus.ex_ready = 1'b0;
        driveIf(1'b1, enc(7'd0, 5'd2, 5'd1, 3'd0, 5'd3, OP), 32'h304, 32'h1, 32'h2, 1'b1, 5'd4, 32'h1234);
        #1 checkOutput("bp_ready", 32'(bus.id_ready), 32'd0);
        tick();
        checkOutput("bp_refresh_rs2", bus.ex_rs2_val, 32'h1234);
        checkOutput("bp_hold_rs1", bus.ex_rs1_val, 32'h50);
        checkOutput("bp_hold_instr", bus.ex_instr, sub_x7_x5_x4);
        checkOutput("bp_hold_valid", 32'(bus.ex_valid), 32'd1);
        bus.ex_ready = 1'b1;
        driveIf(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();

        // Flush wins over backpressure and hazard
        loadInEx();
        driveIf(1'b1, add_x6_x5_x4, 32'h400, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0);
        bus.ex_ready = 1'b0;
        bus.ex_flush = 1'b1;
        #1 checkOutput("flush_ready", 32'(bus.id_ready), 32'd0);
        tick();
        checkOutput("flush_valid", 32'(bus.ex_valid), 32'd0);
        bus.ex_flush = 1'b0;
        bus.ex_ready = 1'b1;

        // Async reset during a load-use stall
        loadInEx();
        driveIf(1'b1, add_x6_x5_x4, 32'h500, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0);
        #1 checkOutput("ar_stall_ready", 32'(bus.id_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("ar_valid_now", 32'(bus.ex_valid), 32'd0);
        checkOutput("ar_load_now", 32'(bus.ex_is_load), 32'd0);
        checkOutput("ar_pc_now", bus.ex_pc, 32'd0);
        tick();
        checkOutput("ar_valid_held", 32'(bus.ex_valid), 32'd0);
        #2 rst_n = 1'b1;
        driveIf(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        checkOutput("ar_after_release", 32'(bus.ex_valid), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
